// File: rtl/product_accumulator_if.sv
// Handshake bundle between the multiplier product stream, the frame accumulator
// and the sum consumer.
interface product_accumulator_if #(
   parameter int ACC_WIDTH = 8
);
   logic                 clear;
   logic [4:0]           product_in;
   logic                 product_valid;
   logic                 product_ready;
   logic [ACC_WIDTH-1:0] sum_out;
   logic                 sum_valid;
   logic                 sum_ready;
   logic                 overflow;
   logic [7:0]           beat_count;

   modport master (
      output clear, product_in, product_valid, sum_ready,
      input  product_ready, sum_out, sum_valid, overflow, beat_count
   );

   modport slave (
      input  clear, product_in, product_valid, sum_ready,
      output product_ready, sum_out, sum_valid, overflow, beat_count
   );
endinterface

// File: rtl/product_accumulator.sv
// Sums frames of COUNT unsigned 5-bit products and hands each frame sum
// downstream over a valid/ready handshake.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ACCUMULATE | accepting products, building the frame sum
// HOLD       | frame sum presented, waiting for sum_ready (or clear)
module product_accumulator #(
   parameter int COUNT     = 4,
   parameter int ACC_WIDTH = 8
) (
   input  logic                    clock,
   input  logic                    reset_n,
   product_accumulator_if.slave    bus
);

   typedef enum logic {
      ACCUMULATE = 1'b0,
      HOLD       = 1'b1
   } state_t;

   state_t               state_q;
   state_t               state_d;
   logic [ACC_WIDTH-1:0] acc_q;
   logic [ACC_WIDTH-1:0] sum_q;
   logic                 ovf_q;
   logic [7:0]           beat_q;

   logic                 product_ready;
   logic                 sum_valid;
   logic                 beat;
   logic                 last_beat;
   logic                 handoff;
   logic [ACC_WIDTH:0]   acc_ext;

   // One extra bit on the adder captures the carry-out for the sticky overflow.
   assign acc_ext   = {1'b0, acc_q} + {{(ACC_WIDTH-4){1'b0}}, bus.product_in};
   assign beat      = bus.product_valid & product_ready;
   assign last_beat = (beat_q == 8'(COUNT - 1));
   assign handoff   = (state_q == HOLD) & (bus.clear | bus.sum_ready);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ACCUMULATE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ACCUMULATE: if (beat && last_beat) state_d = HOLD;
         HOLD:       if (handoff)           state_d = ACCUMULATE;
         default:                           state_d = ACCUMULATE;
      endcase
   end

   always_comb begin
      product_ready = 1'b0;
      sum_valid     = 1'b0;
      case (state_q)
         ACCUMULATE: product_ready = !bus.clear;
         HOLD:       sum_valid     = 1'b1;
         default: ;
      endcase
   end

   // sum_q is deliberately not cleared on clear/handoff: it keeps the last sum.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         acc_q  <= '0;
         sum_q  <= '0;
         ovf_q  <= 1'b0;
         beat_q <= 8'd0;
      end else if (bus.clear || handoff) begin
         acc_q  <= '0;
         ovf_q  <= 1'b0;
         beat_q <= 8'd0;
      end else if (beat) begin
         acc_q  <= acc_ext[ACC_WIDTH-1:0];
         ovf_q  <= ovf_q | acc_ext[ACC_WIDTH];
         beat_q <= beat_q + 8'd1;
         if (last_beat) begin
            sum_q <= acc_ext[ACC_WIDTH-1:0];
         end
      end
   end

   assign bus.product_ready = product_ready;
   assign bus.sum_valid     = sum_valid;
   assign bus.sum_out       = sum_q;
   assign bus.overflow      = ovf_q;
   assign bus.beat_count    = beat_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench: two accumulators (8-bit and 6-bit sums) fed identical stimulus.
module tb_product_accumulator;

   logic       clock;
   logic       reset_n;
   logic       valid;
   logic [4:0] prod;
   logic       clr;
   logic       sready;

   int n_checks;
   int n_pass;

   product_accumulator_if #(.ACC_WIDTH(8)) bus8 ();
   product_accumulator_if #(.ACC_WIDTH(6)) bus6 ();

   assign bus8.product_valid = valid;
   assign bus8.product_in    = prod;
   assign bus8.clear         = clr;
   assign bus8.sum_ready     = sready;
   assign bus6.product_valid = valid;
   assign bus6.product_in    = prod;
   assign bus6.clear         = clr;
   assign bus6.sum_ready     = sready;

   product_accumulator #(.COUNT(4), .ACC_WIDTH(8)) u_dut8 (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus8)
   );

   product_accumulator #(.COUNT(4), .ACC_WIDTH(6)) u_dut6 (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus6)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Present one product for exactly one edge; afterwards park junk on the bus.
   task automatic beat(input logic [4:0] p);
      valid = 1'b1;
      prod  = p;
      tick();
      valid = 1'b0;
      prod  = 5'd31;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      reset_n  = 1'b0;
      valid    = 1'b0;
      prod     = 5'd31;
      clr      = 1'b0;
      sready   = 1'b1;

      tick();
      tick();
      chk("rst_sum_valid", 16'(bus8.sum_valid), 16'd0);
      chk("rst_sum_out",   16'(bus8.sum_out),   16'd0);
      chk("rst_overflow",  16'(bus8.overflow),  16'd0);
      chk("rst_beat",      16'(bus8.beat_count), 16'd0);
      reset_n = 1'b1;
      tick();
      chk("rel_ready",     16'(bus8.product_ready), 16'd1);

      // Back-to-back 21 x4 with sum_ready high
      for (int i = 0; i < 4; i++) beat(5'd21);
      chk("t1_sum_valid",  16'(bus8.sum_valid), 16'd1);
      chk("t1_sum_out",    16'(bus8.sum_out),   16'd84);
      chk("t1_overflow",   16'(bus8.overflow),  16'd0);
      chk("t1_ready_hold", 16'(bus8.product_ready), 16'd0);
      chk("t1_beat_hold",  16'(bus8.beat_count), 16'd4);
      chk("t1w6_sum_out",  16'(bus6.sum_out),   16'd20);
      chk("t1w6_overflow", 16'(bus6.overflow),  16'd1);
      tick();
      chk("t1_valid_after", 16'(bus8.sum_valid), 16'd0);
      chk("t1_ready_after", 16'(bus8.product_ready), 16'd1);
      chk("t1_beat_after",  16'(bus8.beat_count), 16'd0);

      // Overflow does not carry into the next frame
      for (int i = 0; i < 4; i++) beat(5'd1);
      chk("t3_sum_out",    16'(bus8.sum_out),  16'd4);
      chk("t3w6_sum_out",  16'(bus6.sum_out),  16'd4);
      chk("t3w6_overflow", 16'(bus6.overflow), 16'd0);
      tick();

      // Gapped products, delayed sum_ready
      sready = 1'b0;
      beat(5'd3);
      chk("t2_beat1", 16'(bus8.beat_count), 16'd1);
      tick(); tick();
      chk("t2_beat1_gap", 16'(bus8.beat_count), 16'd1);
      beat(5'd0);
      tick(); tick();
      beat(5'd7);
      tick(); tick();
      beat(5'd5);
      chk("t2_sum_valid", 16'(bus8.sum_valid), 16'd1);
      chk("t2_sum_out",   16'(bus8.sum_out),   16'd15);
      chk("t2_beat_hold", 16'(bus8.beat_count), 16'd4);
      for (int i = 0; i < 3; i++) begin
         valid = 1'b1;
         tick();
         chk("t2_hold_sum",   16'(bus8.sum_out),       16'd15);
         chk("t2_hold_valid", 16'(bus8.sum_valid),     16'd1);
         chk("t2_hold_ready", 16'(bus8.product_ready), 16'd0);
      end
      valid  = 1'b0;
      sready = 1'b1;
      #1;
      chk("t2_ready_sr", 16'(bus8.product_ready), 16'd0);
      tick();
      chk("t2_valid_after", 16'(bus8.sum_valid),  16'd0);
      chk("t2_beat_after",  16'(bus8.beat_count), 16'd0);
      chk("t2_sum_kept",    16'(bus8.sum_out),    16'd15);

      // Clear mid-frame while a product is offered
      beat(5'd10);
      beat(5'd10);
      chk("t4_beat_pre", 16'(bus8.beat_count), 16'd2);
      valid = 1'b1;
      prod  = 5'd10;
      clr   = 1'b1;
      #1;
      chk("t4_ready_clr", 16'(bus8.product_ready), 16'd0);
      tick();
      clr   = 1'b0;
      valid = 1'b0;
      chk("t4_beat_clr", 16'(bus8.beat_count), 16'd0);
      chk("t4_valid",    16'(bus8.sum_valid),  16'd0);
      for (int i = 0; i < 4; i++) beat(5'd1);
      chk("t4_sum_out",  16'(bus8.sum_out),   16'd4);
      chk("t4_sum_valid", 16'(bus8.sum_valid), 16'd1);
      tick();

      // Clear beats sum_ready in HOLD
      sready = 1'b0;
      for (int i = 0; i < 4; i++) beat(5'd21);
      chk("t5_sum_out", 16'(bus8.sum_out), 16'd84);
      clr    = 1'b1;
      sready = 1'b1;
      tick();
      clr = 1'b0;
      #1;
      chk("t5_valid_clr", 16'(bus8.sum_valid),     16'd0);
      chk("t5_ready_clr", 16'(bus8.product_ready), 16'd1);
      chk("t5_beat_clr",  16'(bus8.beat_count),    16'd0);
      for (int i = 0; i < 4; i++) beat(5'd2);
      chk("t5_sum_next", 16'(bus8.sum_out), 16'd8);
      tick();

      // Asynchronous reset during HOLD
      sready = 1'b0;
      for (int i = 0; i < 4; i++) beat(5'd21);
      chk("t6_hold_valid", 16'(bus6.sum_valid), 16'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t6_rst_valid",  16'(bus8.sum_valid),  16'd0);
      chk("t6_rst_sum",    16'(bus8.sum_out),    16'd0);
      chk("t6_rst_beat",   16'(bus8.beat_count), 16'd0);
      chk("t6w6_rst_ovf",  16'(bus6.overflow),   16'd0);
      tick();
      reset_n = 1'b1;
      sready  = 1'b1;
      tick();
      chk("t6_no_partial", 16'(bus8.sum_valid), 16'd0);
      for (int i = 0; i < 4; i++) beat(5'd21);
      chk("t6_sum_out",   16'(bus8.sum_out),   16'd84);
      chk("t6_sum_valid", 16'(bus8.sum_valid), 16'd1);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
